// File: rtl/wb_bank_arb_pkg.sv
// Shared types, default widths and address-decode helpers for wb_bank_arbiter.
package wb_bank_arb_pkg;

  localparam int unsigned DataWDef      = 32;
  localparam int unsigned AddrWDef      = 32;
  localparam int unsigned BankAwDef     = 8;
  localparam int unsigned BankSelBitDef = 10;

  typedef enum logic [1:0] {IDLE, RD, ACK} port_state_t;

  // Names the port that wins the next same-bank conflict.
  typedef enum logic {PortA = 1'b0, PortB = 1'b1} port_id_t;

  // Bank index of a byte address (address zero-extended to 64 bits by the caller).
  function automatic logic bank_of(input logic [63:0] addr, input int unsigned sel_bit);
    return addr[sel_bit[5:0]];
  endfunction

  // Any address bit above the bank-select bit is outside the two banks.
  function automatic logic out_of_range(input logic [63:0] addr, input int unsigned sel_bit);
    return (addr >> (sel_bit + 1)) != 64'd0;
  endfunction

endpackage

// File: rtl/wb_bank_arb_port.sv
// Per-port access sequencer: IDLE -> RD -> ACK, read-data capture and ack/err pulse.
// The err path only ever fires when the top level reports out-of-range requests
// (WB_BANK_ARB_ERR_EN); otherwise oor_i is held low and err_o stays 0.
module wb_bank_arb_port
  import wb_bank_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gnt_i,
  input  logic              bank_i,
  input  logic              oor_i,
  input  logic [DATA_W-1:0] b0_do_i,
  input  logic [DATA_W-1:0] b1_do_i,
  output logic              idle_o,
  output logic              ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] data_o
);

  port_state_t       state_q, state_d;
  logic              bank_q, bank_d;
  logic              oor_q, oor_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next-state: grant launches the access, RD captures bank data, ACK pulses completion.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    oor_d   = oor_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_i) begin
          state_d = RD;
          bank_d  = bank_i;
          oor_d   = oor_i;
        end
      end
      RD: begin
        state_d = ACK;
        data_d  = oor_q ? '0 : (bank_q ? b1_do_i : b0_do_i);
        ack_d   = ~oor_q;
        err_d   = oor_q;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight access without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
      oor_q   <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      oor_q   <= oor_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign idle_o = (state_q == IDLE);
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign data_o = data_q;

endmodule

// File: rtl/wb_bank_arbiter.sv
// Two Wishbone classic slave ports sharing two single-port SRAM banks.
// Different-bank requests run in parallel; same-bank requests are arbitrated
// round-robin per bank. Define WB_BANK_ARB_ERR_EN to error out-of-range addresses
// instead of letting them alias.
module wb_bank_arbiter
  import wb_bank_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = DataWDef,
  parameter int unsigned ADDR_W       = AddrWDef,
  parameter int unsigned BANK_AW      = BankAwDef,
  parameter int unsigned BANK_SEL_BIT = BankSelBitDef
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   pa_wb_addr_i,
  input  logic [DATA_W-1:0]   pa_wb_data_i,
  input  logic [DATA_W/8-1:0] pa_wb_sel_i,
  input  logic                pa_wb_we_i,
  input  logic                pa_wb_stb_i,
  input  logic                pa_wb_cyc_i,
  output logic [DATA_W-1:0]   pa_wb_data_o,
  output logic                pa_wb_ack_o,
  output logic                pa_wb_stall_o,
  output logic                pa_wb_err_o,
  input  logic [ADDR_W-1:0]   pb_wb_addr_i,
  input  logic [DATA_W-1:0]   pb_wb_data_i,
  input  logic [DATA_W/8-1:0] pb_wb_sel_i,
  input  logic                pb_wb_we_i,
  input  logic                pb_wb_stb_i,
  input  logic                pb_wb_cyc_i,
  output logic [DATA_W-1:0]   pb_wb_data_o,
  output logic                pb_wb_ack_o,
  output logic                pb_wb_stall_o,
  output logic                pb_wb_err_o,
  output logic                b0_en_o,
  output logic [DATA_W/8-1:0] b0_we_o,
  output logic [BANK_AW-1:0]  b0_addr_o,
  output logic [DATA_W-1:0]   b0_di_o,
  input  logic [DATA_W-1:0]   b0_do_i,
  output logic                b1_en_o,
  output logic [DATA_W/8-1:0] b1_we_o,
  output logic [BANK_AW-1:0]  b1_addr_o,
  output logic [DATA_W-1:0]   b1_di_o,
  input  logic [DATA_W-1:0]   b1_do_i
);

  logic               idle_a, idle_b;
  logic               req_a, req_b;
  logic               bank_a, bank_b;
  logic               oor_a, oor_b;
  logic               a_b0, a_b1, b_b0, b_b1;
  logic               gnt_a0, gnt_a1, gnt_b0, gnt_b1;
  logic               gnt_a, gnt_b;
  port_id_t           prio0_q, prio0_d, prio1_q, prio1_d;
  logic [BANK_AW-1:0] waddr_a, waddr_b;
  logic               unused_addr;

  // Only the word index, bank bit and (optionally) the range bits are decoded.
  assign unused_addr = ^{pa_wb_addr_i, pb_wb_addr_i};

  assign waddr_a = pa_wb_addr_i[BANK_AW+1:2];
  assign waddr_b = pb_wb_addr_i[BANK_AW+1:2];
  assign bank_a  = bank_of(64'(pa_wb_addr_i), BANK_SEL_BIT);
  assign bank_b  = bank_of(64'(pb_wb_addr_i), BANK_SEL_BIT);

`ifdef WB_BANK_ARB_ERR_EN
  assign oor_a = out_of_range(64'(pa_wb_addr_i), BANK_SEL_BIT);
  assign oor_b = out_of_range(64'(pb_wb_addr_i), BANK_SEL_BIT);
`else
  assign oor_a = 1'b0;
  assign oor_b = 1'b0;
`endif

  // Requests are masked during reset so nothing is granted or stalled then.
  assign req_a = pa_wb_cyc_i & pa_wb_stb_i & idle_a & ~rst;
  assign req_b = pb_wb_cyc_i & pb_wb_stb_i & idle_b & ~rst;

  // Out-of-range requests never compete for a bank.
  assign a_b0 = req_a & ~oor_a & ~bank_a;
  assign a_b1 = req_a & ~oor_a &  bank_a;
  assign b_b0 = req_b & ~oor_b & ~bank_b;
  assign b_b1 = req_b & ~oor_b &  bank_b;

  // Per-bank grant; on conflict the flagged port wins and the flag passes to the loser.
  always_comb begin
    gnt_a0  = a_b0 & (~b_b0 | (prio0_q == PortA));
    gnt_b0  = b_b0 & (~a_b0 | (prio0_q == PortB));
    gnt_a1  = a_b1 & (~b_b1 | (prio1_q == PortA));
    gnt_b1  = b_b1 & (~a_b1 | (prio1_q == PortB));
    prio0_d = prio0_q;
    prio1_d = prio1_q;
    if (a_b0 && b_b0) prio0_d = gnt_a0 ? PortB : PortA;
    if (a_b1 && b_b1) prio1_d = gnt_a1 ? PortB : PortA;
  end

  assign gnt_a = gnt_a0 | gnt_a1 | (req_a & oor_a);
  assign gnt_b = gnt_b0 | gnt_b1 | (req_b & oor_b);

  assign pa_wb_stall_o = req_a & ~gnt_a;
  assign pb_wb_stall_o = req_b & ~gnt_b;

  // Round-robin flags, both favouring port A out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio0_q <= PortA;
      prio1_q <= PortA;
    end else begin
      prio0_q <= prio0_d;
      prio1_q <= prio1_d;
    end
  end

  // Bank-side muxing: the granted port drives the bank in its grant cycle only.
  always_comb begin
    b0_en_o   = gnt_a0 | gnt_b0;
    b0_we_o   = '0;
    b0_addr_o = '0;
    b0_di_o   = '0;
    b1_en_o   = gnt_a1 | gnt_b1;
    b1_we_o   = '0;
    b1_addr_o = '0;
    b1_di_o   = '0;
    if (gnt_a0) begin
      b0_we_o   = pa_wb_we_i ? pa_wb_sel_i : '0;
      b0_addr_o = waddr_a;
      b0_di_o   = pa_wb_data_i;
    end else if (gnt_b0) begin
      b0_we_o   = pb_wb_we_i ? pb_wb_sel_i : '0;
      b0_addr_o = waddr_b;
      b0_di_o   = pb_wb_data_i;
    end
    if (gnt_a1) begin
      b1_we_o   = pa_wb_we_i ? pa_wb_sel_i : '0;
      b1_addr_o = waddr_a;
      b1_di_o   = pa_wb_data_i;
    end else if (gnt_b1) begin
      b1_we_o   = pb_wb_we_i ? pb_wb_sel_i : '0;
      b1_addr_o = waddr_b;
      b1_di_o   = pb_wb_data_i;
    end
  end

  wb_bank_arb_port #(
    .DATA_W(DATA_W)
  ) u_port_a (
    .clk    (clk),
    .rst    (rst),
    .gnt_i  (gnt_a),
    .bank_i (bank_a),
    .oor_i  (oor_a),
    .b0_do_i(b0_do_i),
    .b1_do_i(b1_do_i),
    .idle_o (idle_a),
    .ack_o  (pa_wb_ack_o),
    .err_o  (pa_wb_err_o),
    .data_o (pa_wb_data_o)
  );

  wb_bank_arb_port #(
    .DATA_W(DATA_W)
  ) u_port_b (
    .clk    (clk),
    .rst    (rst),
    .gnt_i  (gnt_b),
    .bank_i (bank_b),
    .oor_i  (oor_b),
    .b0_do_i(b0_do_i),
    .b1_do_i(b1_do_i),
    .idle_o (idle_b),
    .ack_o  (pb_wb_ack_o),
    .err_o  (pb_wb_err_o),
    .data_o (pb_wb_data_o)
  );

endmodule

// File: tb/tb_wb_bank_arbiter.sv
// Scoreboard bench for wb_bank_arbiter: directed transfers push expected responses,
// a negedge monitor pops them on every ack/err.
module tb_wb_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pa_wb_addr_i = '0, pb_wb_addr_i = '0;
  logic [31:0] pa_wb_data_i = '0, pb_wb_data_i = '0;
  logic [3:0]  pa_wb_sel_i = '0, pb_wb_sel_i = '0;
  logic        pa_wb_we_i = 1'b0, pb_wb_we_i = 1'b0;
  logic        pa_wb_stb_i = 1'b0, pb_wb_stb_i = 1'b0;
  logic        pa_wb_cyc_i = 1'b0, pb_wb_cyc_i = 1'b0;
  logic [31:0] pa_wb_data_o, pb_wb_data_o;
  logic        pa_wb_ack_o, pb_wb_ack_o, pa_wb_stall_o, pb_wb_stall_o;
  logic        pa_wb_err_o, pb_wb_err_o;
  logic        b0_en_o, b1_en_o;
  logic [3:0]  b0_we_o, b1_we_o;
  logic [7:0]  b0_addr_o, b1_addr_o;
  logic [31:0] b0_di_o, b1_di_o;
  logic [31:0] b0_do_i, b1_do_i;

  wb_bank_arbiter u_dut (
    .clk          (clk),
    .rst          (rst),
    .pa_wb_addr_i (pa_wb_addr_i),
    .pa_wb_data_i (pa_wb_data_i),
    .pa_wb_sel_i  (pa_wb_sel_i),
    .pa_wb_we_i   (pa_wb_we_i),
    .pa_wb_stb_i  (pa_wb_stb_i),
    .pa_wb_cyc_i  (pa_wb_cyc_i),
    .pa_wb_data_o (pa_wb_data_o),
    .pa_wb_ack_o  (pa_wb_ack_o),
    .pa_wb_stall_o(pa_wb_stall_o),
    .pa_wb_err_o  (pa_wb_err_o),
    .pb_wb_addr_i (pb_wb_addr_i),
    .pb_wb_data_i (pb_wb_data_i),
    .pb_wb_sel_i  (pb_wb_sel_i),
    .pb_wb_we_i   (pb_wb_we_i),
    .pb_wb_stb_i  (pb_wb_stb_i),
    .pb_wb_cyc_i  (pb_wb_cyc_i),
    .pb_wb_data_o (pb_wb_data_o),
    .pb_wb_ack_o  (pb_wb_ack_o),
    .pb_wb_stall_o(pb_wb_stall_o),
    .pb_wb_err_o  (pb_wb_err_o),
    .b0_en_o      (b0_en_o),
    .b0_we_o      (b0_we_o),
    .b0_addr_o    (b0_addr_o),
    .b0_di_o      (b0_di_o),
    .b0_do_i      (b0_do_i),
    .b1_en_o      (b1_en_o),
    .b1_we_o      (b1_we_o),
    .b1_addr_o    (b1_addr_o),
    .b1_di_o      (b1_di_o),
    .b1_do_i      (b1_do_i)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Bank macro models: registered read (old data), byte-lane writes.
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  always @(posedge clk) begin
    if (b0_en_o) begin
      b0_do_i <= mem0[b0_addr_o];
      for (int i = 0; i < 4; i++) if (b0_we_o[i]) mem0[b0_addr_o][8*i +: 8] <= b0_di_o[8*i +: 8];
    end
    if (b1_en_o) begin
      b1_do_i <= mem1[b1_addr_o];
      for (int i = 0; i < 4; i++) if (b1_we_o[i]) mem1[b1_addr_o][8*i +: 8] <= b1_di_o[8*i +: 8];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          we;
    bit          err;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  typedef struct {
    bit          v;
    bit          we;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          stall;
    logic [31:0] exp;
    bit          err;
  } req_t;

  function automatic req_t mk(input bit we, input logic [31:0] addr, input logic [31:0] dat,
                              input logic [3:0] sel, input int stall, input bit err);
    req_t r;
    r.v = 1'b1; r.we = we; r.addr = addr; r.dat = we ? dat : 32'h0;
    r.sel = sel; r.stall = stall; r.exp = we ? 32'h0 : dat; r.err = err;
    return r;
  endfunction

  req_t none = '{v: 1'b0, we: 1'b0, addr: 32'h0, dat: 32'h0, sel: 4'h0, stall: 0, exp: 32'h0,
                 err: 1'b0};

  // Monitor: every ack/err must match the oldest expected response of that port.
  always @(negedge clk) begin
    exp_t e;
    if (pa_wb_ack_o || pa_wb_err_o) begin
      if (qa.size() == 0) chk("A unexpected response", 32'h1, 32'h0);
      else begin
        e = qa.pop_front();
        chk("A ack", 32'(pa_wb_ack_o), 32'(!e.err));
        chk("A err", 32'(pa_wb_err_o), 32'(e.err));
        chk("A ack cycle", cyc_cnt, e.cyc);
        if (!e.we || e.err) chk("A read data", pa_wb_data_o, e.dat);
      end
    end
    if (pb_wb_ack_o || pb_wb_err_o) begin
      if (qb.size() == 0) chk("B unexpected response", 32'h1, 32'h0);
      else begin
        e = qb.pop_front();
        chk("B ack", 32'(pb_wb_ack_o), 32'(!e.err));
        chk("B err", 32'(pb_wb_err_o), 32'(e.err));
        chk("B ack cycle", cyc_cnt, e.cyc);
        if (!e.we || e.err) chk("B read data", pb_wb_data_o, e.dat);
      end
    end
  end

  // Issue up to one transfer per port in the same cycle and hold each until its response.
  // en_s/we0_s/addr0_s snapshot the bank side in the issue cycle.
  task automatic xfer(input string name, input req_t ra, input req_t rb,
                      output logic [1:0] en_s, output logic [3:0] we0_s,
                      output logic [7:0] addr0_s);
    int k, sa, sb, n;
    bit da, db;
    @(posedge clk); #1;
    k = cyc_cnt;
    if (ra.v) begin
      pa_wb_addr_i = ra.addr; pa_wb_data_i = ra.dat; pa_wb_sel_i = ra.sel;
      pa_wb_we_i = ra.we; pa_wb_cyc_i = 1'b1; pa_wb_stb_i = 1'b1;
      qa.push_back('{we: ra.we, err: ra.err, dat: ra.exp, cyc: k + 2 + ra.stall});
    end
    if (rb.v) begin
      pb_wb_addr_i = rb.addr; pb_wb_data_i = rb.dat; pb_wb_sel_i = rb.sel;
      pb_wb_we_i = rb.we; pb_wb_cyc_i = 1'b1; pb_wb_stb_i = 1'b1;
      qb.push_back('{we: rb.we, err: rb.err, dat: rb.exp, cyc: k + 2 + rb.stall});
    end
    da = !ra.v; db = !rb.v; sa = 0; sb = 0; n = 0;
    en_s = '0; we0_s = '0; addr0_s = '0;
    while (!(da && db) && n < 20) begin
      @(negedge clk);
      if (n == 0) begin
        en_s = {b1_en_o, b0_en_o}; we0_s = b0_we_o; addr0_s = b0_addr_o;
      end
      if (!da && pa_wb_stall_o) sa++;
      if (!db && pb_wb_stall_o) sb++;
      if (pa_wb_ack_o || pa_wb_err_o) da = 1'b1;
      if (pb_wb_ack_o || pb_wb_err_o) db = 1'b1;
      @(posedge clk); #1;
      if (da) begin pa_wb_cyc_i = 1'b0; pa_wb_stb_i = 1'b0; pa_wb_we_i = 1'b0; end
      if (db) begin pb_wb_cyc_i = 1'b0; pb_wb_stb_i = 1'b0; pb_wb_we_i = 1'b0; end
      n++;
    end
    chk({name, " A completed"}, 32'(da), 32'h1);
    chk({name, " B completed"}, 32'(db), 32'h1);
    if (ra.v) chk({name, " A stall cycles"}, sa, ra.stall);
    if (rb.v) chk({name, " B stall cycles"}, sb, rb.stall);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] en;
    logic [3:0] we0;
    logic [7:0] ad0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ack/stall/err", {26'h0, pa_wb_ack_o, pb_wb_ack_o, pa_wb_stall_o, pb_wb_stall_o,
                                pa_wb_err_o, pb_wb_err_o}, 32'h0);
    chk("reset A data", pa_wb_data_o, 32'h0);
    chk("reset B data", pb_wb_data_o, 32'h0);
    chk("reset bank en/we", {22'h0, b0_en_o, b1_en_o, b0_we_o, b1_we_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single write then read on bank0
    xfer("t1 wr", mk(1, 32'h000, 32'hDEADBEEF, 4'hF, 0, 0), none, en, we0, ad0);
    chk("t1 bank en at grant", 32'(en), 32'h1);
    chk("t1 bank0 we", 32'(we0), 32'hF);
    chk("t1 bank0 addr", 32'(ad0), 32'h0);
    xfer("t1 rd", mk(0, 32'h000, 32'hDEADBEEF, 4'hF, 0, 0), none, en, we0, ad0);
    chk("t1 rd we0", 32'(we0), 32'h0);

    // 2: different banks in parallel
    xfer("t2 wr", mk(1, 32'h004, 32'h12345678, 4'hF, 0, 0),
         mk(1, 32'h404, 32'h87654321, 4'hF, 0, 0), en, we0, ad0);
    chk("t2 both banks enabled", 32'(en), 32'h3);
    chk("t2 bank0 addr", 32'(ad0), 32'h1);
    xfer("t2 rd", mk(0, 32'h004, 32'h12345678, 4'hF, 0, 0),
         mk(0, 32'h404, 32'h87654321, 4'hF, 0, 0), en, we0, ad0);

    // 3: same-bank conflict, A wins out of reset
    xfer("t3 wr", mk(1, 32'h008, 32'hAAAABBBB, 4'hF, 0, 0),
         mk(1, 32'h00C, 32'hCCCCDDDD, 4'hF, 1, 0), en, we0, ad0);
    chk("t3 bank0 addr is A", 32'(ad0), 32'h2);

    // 4: next conflict goes to B
    xfer("t4 wr", mk(1, 32'h010, 32'h01020304, 4'hF, 1, 0),
         mk(1, 32'h014, 32'h05060708, 4'hF, 0, 0), en, we0, ad0);
    chk("t4 bank0 addr is B", 32'(ad0), 32'h5);

    // Readbacks keep alternating the bank0 winner
    xfer("t3 rd", mk(0, 32'h008, 32'hAAAABBBB, 4'hF, 0, 0),
         mk(0, 32'h00C, 32'hCCCCDDDD, 4'hF, 1, 0), en, we0, ad0);
    xfer("t4 rd", mk(0, 32'h010, 32'h01020304, 4'hF, 1, 0),
         mk(0, 32'h014, 32'h05060708, 4'hF, 0, 0), en, we0, ad0);

    // Byte lanes on bank1 from port B
    xfer("lane full", none, mk(1, 32'h420, 32'hFFFFFFFF, 4'hF, 0, 0), en, we0, ad0);
    xfer("lane part", none, mk(1, 32'h420, 32'h11223344, 4'h5, 0, 0), en, we0, ad0);
    chk("lane part bank1 only", 32'(en), 32'h2);
    xfer("lane rd", none, mk(0, 32'h420, 32'hFF22FF44, 4'hF, 0, 0), en, we0, ad0);

`ifndef WB_BANK_ARB_ERR_EN
    // High address bits alias onto the banks
    xfer("alias rd", mk(0, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0), none, en, we0, ad0);
    chk("alias bank0 en", 32'(en), 32'h1);
`endif

    // 5: reset while A is in RD drops the access
    @(posedge clk); #1;
    pa_wb_addr_i = 32'h000; pa_wb_we_i = 1'b0; pa_wb_sel_i = 4'hF;
    pa_wb_cyc_i = 1'b1; pa_wb_stb_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; pa_wb_cyc_i = 1'b0; pa_wb_stb_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5 A ack after reset", 32'(pa_wb_ack_o), 32'h0);
    chk("t5 A data after reset", pa_wb_data_o, 32'h0);
    chk("t5 outputs after reset", {27'h0, pa_wb_stall_o, pb_wb_stall_o, b0_en_o, b1_en_o,
                                   pa_wb_err_o}, 32'h0);
    @(negedge clk);
    chk("t5 A still no ack", 32'(pa_wb_ack_o), 32'h0);
    xfer("t5 rd", mk(0, 32'h004, 32'h12345678, 4'hF, 0, 0), none, en, we0, ad0);
    xfer("t5 prio reset", mk(0, 32'h000, 32'hDEADBEEF, 4'hF, 0, 0),
         mk(0, 32'h008, 32'hAAAABBBB, 4'hF, 1, 0), en, we0, ad0);

`ifdef WB_BANK_ARB_ERR_EN
    // 6: out-of-range read errors without touching a bank
    xfer("t6 oor", mk(0, 32'h800, 32'h0, 4'hF, 0, 1), none, en, we0, ad0);
    chk("t6 no bank en", 32'(en), 32'h0);
`endif

    repeat (4) @(posedge clk);
    chk("A queue drained", qa.size(), 0);
    chk("B queue drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
